// File: rtl/gh_counter_updn_rld_tc.sv
// Up/down counter with a writable reload register. It runs in one-shot mode
// (stops at the terminal value and sets a sticky DONE) or periodic mode (auto-reloads).
module gh_counter_updn_rld_tc #(
  parameter int unsigned          SIZE     = 8,
  parameter logic [SIZE-1:0]      RLD_INIT = '1
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            LOAD,
  input  logic            CE,
  input  logic            UP,
  input  logic            MODE,
  input  logic [SIZE-1:0] D,
  input  logic            WR_RLD,
  input  logic [SIZE-1:0] RLD_D,
  output logic [SIZE-1:0] Q,
  output logic [SIZE-1:0] RLD_Q,
  output logic            TC,
  output logic            DONE
);

  logic [SIZE-1:0] q;
  logic [SIZE-1:0] rld_q;
  logic            done;
  logic [SIZE-1:0] term_val;
  logic [SIZE-1:0] reload_val;
  logic            at_term;

  // Terminal and reload values come from the pre-write reload register, so a
  // same-cycle WR_RLD only becomes visible on the following cycle.
  always_comb begin
    term_val   = UP ? rld_q : '0;
    reload_val = UP ? '0    : rld_q;
    at_term    = (q == term_val);
  end

  assign TC    = CE & ~LOAD & at_term & ~done;
  assign Q     = q;
  assign RLD_Q = rld_q;
  assign DONE  = done;

  always_ff @(posedge CLK) begin
    if (rst) begin
      q     <= '0;
      rld_q <= RLD_INIT;
      done  <= 1'b0;
    end else begin
      if (WR_RLD)
        rld_q <= RLD_D;
      if (LOAD) begin
        q    <= D;
        done <= 1'b0;
      end else if (CE && !done) begin
        if (!at_term)
          q <= UP ? q + SIZE'(1) : q - SIZE'(1);
        else if (MODE)
          q <= reload_val;
        else
          done <= 1'b1;
      end
    end
  end

endmodule
